// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - iterative radix-2 RV64 divider (DIV/DIVU/REM/REMU and W variants)
//
// Ports:
//   i_riscv_clk, i_riscv_rst_n      clock, asynchronous active-low reset
//   i_riscv_div_valid               divide instruction present in execute (held while stalled)
//   i_riscv_div_op[2:0]             {word, unsigned, rem}
//   i_riscv_div_rs1 / _rs2          dividend / divisor, sampled only when an operation starts
//   i_riscv_div_flush               synchronous abort, returns to IDLE at the next edge
//   o_riscv_div_result              registered result, held until the next completion
//   o_riscv_div_done                one-cycle result-valid pulse
//   o_riscv_div_stall               combinational stall request to the hazard unit
//   o_riscv_div_busy                FSM is not IDLE
//
// Build option: RISCV_DIV_FAST_SPECIAL_EN - when defined, divide-by-zero and signed
// overflow complete straight from IDLE to DONE instead of running all iterations.
module riscv_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_clk,
    input  logic            i_riscv_rst_n,
    input  logic            i_riscv_div_valid,
    input  logic [2:0]      i_riscv_div_op,
    input  logic [XLEN-1:0] i_riscv_div_rs1,
    input  logic [XLEN-1:0] i_riscv_div_rs2,
    input  logic            i_riscv_div_flush,
    output logic [XLEN-1:0] o_riscv_div_result,
    output logic            o_riscv_div_done,
    output logic            o_riscv_div_stall,
    output logic            o_riscv_div_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [63:0] q_reg;         // dividend shifting out at the top, quotient bits in at the bottom
    logic [63:0] r_reg;         // partial remainder, always < d_reg
    logic [63:0] d_reg;         // divisor magnitude
    logic        neg_q;
    logic        neg_r;
    logic        op_rem;
    logic        op_word;
    logic        special_pend;
    logic [63:0] special_reg;

    // Low 32 bits sign-extended for word ops, pass-through otherwise.
    function automatic logic [63:0] wext(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation from the live inputs, used only at start.
    logic        in_rem, in_uns, in_word;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, special_res;
    logic        a_neg, b_neg, div_zero, sgn_ovf, is_special;

    always_comb begin
        in_rem  = i_riscv_div_op[0];
        in_uns  = i_riscv_div_op[1];
        in_word = i_riscv_div_op[2];
        a_ext = in_word ? (in_uns ? {32'd0, i_riscv_div_rs1[31:0]}
                                  : {{32{i_riscv_div_rs1[31]}}, i_riscv_div_rs1[31:0]})
                        : i_riscv_div_rs1;
        b_ext = in_word ? (in_uns ? {32'd0, i_riscv_div_rs2[31:0]}
                                  : {{32{i_riscv_div_rs2[31]}}, i_riscv_div_rs2[31:0]})
                        : i_riscv_div_rs2;
        a_neg = ~in_uns & a_ext[63];
        b_neg = ~in_uns & b_ext[63];
        a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;
        div_zero = (b_ext == 64'd0);
        sgn_ovf  = ~in_uns & (b_ext == {64{1'b1}})
                 & (a_ext == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        is_special = div_zero | sgn_ovf;
        if (div_zero)
            special_res = wext(in_word, in_rem ? a_ext : {64{1'b1}});
        else
            special_res = wext(in_word, in_rem ? 64'd0 : a_ext);
    end

    // One restoring step. Because r_reg < d_reg, partial < 2*d_reg, so bit 64 of
    // the trial difference is set exactly when the subtraction would go negative.
    logic [64:0] partial, trial;
    logic        fits;
    logic [63:0] next_q, next_r, q_fix, r_fix, iter_res;
    logic        last_iter;

    always_comb begin
        partial  = {r_reg, q_reg[63]};
        trial    = partial - {1'b0, d_reg};
        fits     = ~trial[64];
        next_r   = fits ? trial[63:0] : partial[63:0];
        next_q   = {q_reg[62:0], fits};
        q_fix    = neg_q ? (~next_q + 64'd1) : next_q;
        r_fix    = neg_r ? (~next_r + 64'd1) : next_r;
        iter_res = wext(op_word, op_rem ? r_fix : q_fix);
        last_iter = (cnt == (op_word ? 6'd31 : 6'd63));
    end

    always_ff @(posedge i_riscv_clk or negedge i_riscv_rst_n) begin
        if (!i_riscv_rst_n) begin
            state              <= S_IDLE;
            cnt                <= 6'd0;
            q_reg              <= 64'd0;
            r_reg              <= 64'd0;
            d_reg              <= 64'd0;
            neg_q              <= 1'b0;
            neg_r              <= 1'b0;
            op_rem             <= 1'b0;
            op_word            <= 1'b0;
            special_pend       <= 1'b0;
            special_reg        <= 64'd0;
            o_riscv_div_result <= '0;
        end else if (i_riscv_div_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_riscv_div_valid) begin
                        neg_q        <= a_neg ^ b_neg;
                        neg_r        <= a_neg;
                        op_rem       <= in_rem;
                        op_word      <= in_word;
                        d_reg        <= b_mag;
                        // Word dividends are pre-aligned to the top so 32 steps suffice.
                        q_reg        <= in_word ? {a_mag[31:0], 32'd0} : a_mag;
                        r_reg        <= 64'd0;
                        cnt          <= 6'd0;
                        special_reg  <= special_res;
                        special_pend <= is_special;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
                        if (is_special) begin
                            state              <= S_DONE;
                            o_riscv_div_result <= special_res;
                        end else begin
                            state <= S_BUSY;
                        end
`else
                        state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    q_reg <= next_q;
                    r_reg <= next_r;
                    cnt   <= cnt + 6'd1;
                    if (last_iter) begin
                        state              <= S_DONE;
                        o_riscv_div_result <= special_pend ? special_reg : iter_res;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_riscv_div_done  = (state == S_DONE);
    assign o_riscv_div_busy  = (state != S_IDLE);
    assign o_riscv_div_stall = ~i_riscv_div_flush
                             & (((state == S_IDLE) & i_riscv_div_valid) | (state == S_BUSY));

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb/tb_riscv_div_unit.sv - self-checking bench for riscv_div_unit
module tb_riscv_div_unit;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [2:0]  op;
    logic [63:0] rs1, rs2;
    logic        flush;
    logic [63:0] result;
    logic        done, stall, busy;

    int checks   = 0;
    int failures = 0;

    riscv_div_unit #(.XLEN(64)) dut (
        .i_riscv_clk        (clk),
        .i_riscv_rst_n      (rst_n),
        .i_riscv_div_valid  (valid),
        .i_riscv_div_op     (op),
        .i_riscv_div_rs1    (rs1),
        .i_riscv_div_rs2    (rs2),
        .i_riscv_div_flush  (flush),
        .o_riscv_div_result (result),
        .o_riscv_div_done   (done),
        .o_riscv_div_stall  (stall),
        .o_riscv_div_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_DIV = 3'd0, OP_REM = 3'd1, OP_DIVU = 3'd2, OP_REMU = 3'd3;
    localparam logic [2:0] OP_DIVW = 3'd4, OP_REMW = 3'd5, OP_DIVUW = 3'd6, OP_REMUW = 3'd7;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // Reference: RISC-V semantics with plain language-level division.
    function automatic logic [63:0] ref_div(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (o[2]) begin
            a32 = x[31:0];
            b32 = y[31:0];
            if (b32 == 32'd0)
                r32 = o[0] ? a32 : 32'hFFFF_FFFF;
            else if (!o[1] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = o[0] ? 32'd0 : a32;
            else if (o[1])
                r32 = o[0] ? (a32 % b32) : (a32 / b32);
            else
                r32 = o[0] ? ($signed(a32) % $signed(b32)) : ($signed(a32) / $signed(b32));
            return {{32{r32[31]}}, r32};
        end
        if (y == 64'd0)
            r64 = o[0] ? x : {64{1'b1}};
        else if (!o[1] && x == 64'h8000_0000_0000_0000 && y == {64{1'b1}})
            r64 = o[0] ? 64'd0 : x;
        else if (o[1])
            r64 = o[0] ? (x % y) : (x / y);
        else
            r64 = o[0] ? ($signed(x) % $signed(y)) : ($signed(x) / $signed(y));
        return r64;
    endfunction

    function automatic bit ref_special(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        if (o[2])
            return (y[31:0] == 32'd0) || (!o[1] && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
        return (y == 64'd0) || (!o[1] && x == 64'h8000_0000_0000_0000 && y == {64{1'b1}});
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input bit special);
`ifdef RISCV_DIV_FAST_SPECIAL_EN
        if (special) return 1;
`endif
        return o[2] ? 33 : 65;
    endfunction

    // Called at #1 after a rising edge; that cycle is cycle 0.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input bit hold, output logic [63:0] res, output int lat, output bit stall_ok);
        valid = 1'b1; op = o; rs1 = a; rs2 = b;
        lat = -1; stall_ok = 1'b1; res = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; res = result;
                if (stall) stall_ok = 1'b0;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        // Scramble operands mid-flight were covered by holding them; now move on.
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [63:0] res, prev;
    int lat;
    bit sok;

    initial begin
        rst_n = 1'b0; valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {63'd0, busy},  64'd0);
        check("reset_done",   {63'd0, done},  64'd0);
        check("reset_stall",  {63'd0, stall}, 64'd0);
        check("reset_result", result,         64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{OP_DIV,   -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 0, "div_m20_3"});
        vecs.push_back('{OP_REM,   -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, "rem_m20_3"});
        vecs.push_back('{OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0, "divuw"});
        vecs.push_back('{OP_REMW,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "remw_m7_2"});
        vecs.push_back('{OP_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_by0"});
        vecs.push_back('{OP_REMU,  64'd100, 64'd0, 64'd100, 1, "remu_by0"});
        vecs.push_back('{OP_DIV,   64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 1, "div_ovf"});
        vecs.push_back('{OP_REM,   64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 1, "rem_ovf"});
        vecs.push_back('{OP_DIVW,  64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf"});
        vecs.push_back('{OP_REMUW, 64'h0000_0000_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, "remuw_by0"});
        vecs.push_back('{OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divuw_sext"});
        vecs.push_back('{OP_DIVU,  {64{1'b1}}, 64'd1, {64{1'b1}}, 0, "divu_max"});

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, 1'b0, res, lat, sok);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(ref_latency(vecs[i].o, vecs[i].special)));
            check({vecs[i].name, "_stall"}, {63'd0, sok}, 64'd1);
        end

        // Back-to-back: DIVU 10/3 then REMU 10/3 with valid held.
        run_op(OP_DIVU, 64'd10, 64'd3, 1'b1, res, lat, sok);
        check("b2b_first_result", res, 64'd3);
        check("b2b_first_latency", 64'(lat), 64'd65);
        check("b2b_second_idle", {63'd0, busy}, 64'd0);
        run_op(OP_REMU, 64'd10, 64'd3, 1'b0, res, lat, sok);
        check("b2b_second_result", res, 64'd1);
        check("b2b_second_latency", 64'(lat), 64'd65);
        check("b2b_second_stall", {63'd0, sok}, 64'd1);

        // Flush in cycle 10.
        prev = result;
        valid = 1'b1; op = OP_DIV; rs1 = 64'd1000; rs2 = 64'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            rs1 = {$urandom, $urandom};
            rs2 = {$urandom, $urandom};
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_low", {63'd0, stall}, 64'd0);
        check("flush_still_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        check("flush_idle", {63'd0, busy}, 64'd0);
        check("flush_no_done", {63'd0, done}, 64'd0);
        check("flush_result_held", result, prev);
        flush = 1'b0; valid = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("flush_never_done", {63'd0, seen}, 64'd0);
        end
        @(posedge clk); #1;

        // Reset in cycle 20 of another operation.
        valid = 1'b1; op = OP_DIVU; rs1 = 64'd999; rs2 = 64'd9;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_result", result, 64'd0);
        valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized operations against the reference.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  o;
            logic [63:0] a, b, e;
            int mode;
            o = 3'($urandom_range(0, 7));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            mode = $urandom_range(0, 9);
            case (mode)
                0: b = o[2] ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    a = o[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = o[2] ? {$urandom, 32'hFFFF_FFFF} : {64{1'b1}};
                end
                2: b = 64'($urandom_range(1, 20));
                3: b = -64'($urandom_range(1, 20));
                4: b = b >> $urandom_range(0, 63);
                default: ;
            endcase
            e = ref_div(o, a, b);
            run_op(o, a, b, 1'b0, res, lat, sok);
            check($sformatf("rand%0d_result", i), res, e);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_latency(o, ref_special(o, a, b))));
            check($sformatf("rand%0d_stall", i), {63'd0, sok}, 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
# riscv_div_unit

Iterative radix-2 integer divider with built-in sequencing FSM for the RV64 execute stage. Executes DIV/DIVU/REM/REMU and their W variants. While an operation is in flight it freezes the pipeline through a stall request to the hazard logic, then presents a one-cycle result for writeback forwarding. It also handles the RISC-V divide-by-zero and signed-overflow special cases and aborts cleanly on a pipeline flush.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- i_riscv_clk, in, 1, core clock; all state changes on its rising edge.
- i_riscv_rst_n, in, 1, reset, asynchronous, active-low.
- i_riscv_div_valid, in, 1, a divide instruction is in execute; held high by the pipeline while stalled.
- i_riscv_div_op, in, 3, operation select:
  - bit0 = rem: 1 returns the remainder, 0 returns the quotient.
  - bit1 = unsigned.
  - bit2 = word (W variant).
- i_riscv_div_rs1, in, 64, dividend; sampled only at start.
- i_riscv_div_rs2, in, 64, divisor; sampled only at start.
- i_riscv_div_flush, in, 1, synchronous abort from branch/jump flush.
- o_riscv_div_result, out, 64, registered result.
- o_riscv_div_done, out, 1, result valid; one-cycle pulse.
- o_riscv_div_stall, out, 1, combinational stall request to the hazard unit.
- o_riscv_div_busy, out, 1, FSM is not IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE → BUSY when valid=1 and flush=0, and the operation is not a special case.
  - Latches |rs1| and |rs2| (magnitudes for signed ops).
  - Latches the quotient-sign and remainder-sign flags.
  - Clears the iteration counter and the partial remainder.
- Iteration count N = 64, or 32 for word ops.
- Word operand preparation: low 32 bits, sign-extended (signed op) or zero-extended (unsigned op).
- BUSY: one restoring shift-subtract iteration per cycle.
  - Counter increments each cycle.
  - At count = N-1 → DONE.
- DONE: result register written at entry, then done=1 for one cycle, then → IDLE unconditionally.
  - A still-high valid in DONE does not restart.
- Sign fix-up for signed ops:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Word results: low 32 bits sign-extended to 64, including DIVUW and REMUW.
- Special cases (result selected at start):
  - Divisor = 0: quotient = all ones; remainder = dividend (word ops: sign-extended low 32 bits).
  - Signed overflow (dividend = most-negative value, divisor = -1; 32-bit for word ops): quotient = dividend; remainder = 0.
- Stall equation: stall = ~flush & ((IDLE & valid) | BUSY).
- Flush in any state: → IDLE at the next edge.
  - Flush takes priority over start.
  - No done pulse; result register unchanged.
- Operand changes during BUSY are ignored.

## Timing
- Reset values:
  - State: IDLE.
  - o_riscv_div_result = 0.
  - o_riscv_div_done = 0.
  - o_riscv_div_busy = 0.
  - o_riscv_div_stall = 0 (valid is low during reset).
- Reset asserted mid-operation aborts immediately to IDLE; no done pulse.
- Cycle numbering: cycle 0 is the first cycle valid is high in IDLE; stall is already high in cycle 0.
- Normal operation:
  - BUSY occupies cycles 1..N.
  - DONE with done=1 and stall=0 occurs in cycle N+1.
  - The pipeline advances at the end of cycle N+1.
- Resulting latency: done in cycle 65 for 64-bit ops and cycle 33 for word ops; stall high N+1 cycles.
- Back-to-back divides: the second is sampled in IDLE in cycle N+2 and stalls from that cycle. There is no bubble beyond the DONE cycle.
- o_riscv_div_result holds its value until the next DONE.

## Configuration
- RISCV_DIV_FAST_SPECIAL_EN:
  - Defined: special cases go IDLE → DONE directly; done in cycle 1; stall high only in cycle 0.
  - Undefined: special cases run the full N-iteration BUSY sequence with the same timing as normal ops. The special-case result is forced at DONE entry.
  - Results are bit-identical either way.

## Test plan
- DIV, rs1 = -20, rs2 = 3: result 0xFFFF_FFFF_FFFF_FFFA (-6) in cycle 65; the same operands with REM give -2. Stall is high in cycles 0–64.
- DIVUW, rs1 = 0x0000_0000_FFFF_FFFE, rs2 = 2: result 0x0000_0000_7FFF_FFFF with done in cycle 33. REMW, rs1 = -7, rs2 = 2: result 0xFFFF_FFFF_FFFF_FFFF.
- DIVU 100/0: result 0xFFFF_FFFF_FFFF_FFFF, and REMU 100/0 gives 100. Done in cycle 1 with the macro defined, cycle 65 without.
- DIV with rs1 = 0x8000_0000_0000_0000, rs2 = -1: result 0x8000_0000_0000_0000, and REM gives 0. DIVW with rs1 low = 0x8000_0000, rs2 = -1: result 0xFFFF_FFFF_8000_0000.
- Flush abort: start DIV, assert flush in cycle 10 → stall low in cycle 10, IDLE in cycle 11, no done, result unchanged. Asserting reset in cycle 20 of another op gives busy = 0 immediately.
- Back-to-back: DIVU 10/3 then REMU 10/3 held consecutively → done in cycle 65 with result 3, second start in cycle 66, done in cycle 131 with result 1.
